// File: rtl/apb_periph_arbiter.sv
// ---------------------------------------------------------------------------
// apb_periph_arbiter
//
// Shares one APB master port toward the peripheral address decoder between
// NUM_REQ APB requesters. Arbitration is round-robin and happens only in
// IDLE. The winner's address, write flag and write data are registered at
// selection, so the shared bus is driven from registers.
//
// Handshake: a requester holds req_psel_i high until it sees req_pready_o.
// The response (req_prdata_o / req_pslverr_o) is valid only in the cycle
// where req_pready_o is high. The shared side follows plain APB: the
// SETUP cycle has psel_o=1 and penable_o=0. The ACCESS cycles have
// psel_o=1 and penable_o=1 and last until pready_i=1 or the timeout fires.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_psel_i             per-requester PSEL (request)
//   req_penable_i          per-requester PENABLE (ignored for sequencing)
//   req_pwrite_i           per-requester PWRITE
//   req_paddr_i            per-requester PADDR, packed, requester i at [i*AW +: AW]
//   req_pwdata_i           per-requester PWDATA, packed likewise
//   req_prdata_o           per-requester PRDATA, zero for non-winners
//   req_pready_o           per-requester PREADY
//   req_pslverr_o          per-requester PSLVERR
//   psel_o, penable_o      shared APB control
//   pwrite_o, paddr_o,
//   pwdata_o               shared APB transfer attributes (registered)
//   prdata_i, pready_i,
//   pslverr_i              shared APB response
//   grant_o                one-hot owner in SETUP/ACCESS, zero in IDLE
//   timeout_o              one-cycle pulse when a transfer is forced to end
//   state_o                current FSM state (debug): 0 IDLE, 1 SETUP, 2 ACCESS
// ---------------------------------------------------------------------------
module apb_periph_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_psel_i,
  input  logic [NUM_REQ-1:0]                  req_penable_i,
  input  logic [NUM_REQ-1:0]                  req_pwrite_i,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_paddr_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_pwdata_i,
  output logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_prdata_o,
  output logic [NUM_REQ-1:0]                  req_pready_o,
  output logic [NUM_REQ-1:0]                  req_pslverr_o,
  output logic                                psel_o,
  output logic                                penable_o,
  output logic                                pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]           prdata_i,
  input  logic                                pready_i,
  input  logic                                pslverr_i,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic                                timeout_o,
  output logic [1:0]                          state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            last_grant_q;
  logic [IDX_W-1:0]            winner_q;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q;
  logic                        pwrite_q;
  logic [15:0]                 cnt_q;
  // Set once the winner drops psel after selection; its response is then
  // thrown away even if psel comes back before completion.
  logic                        abandon_q;

  logic                        found;
  logic [IDX_W-1:0]            pick;
  logic [IDX_W:0]              cand;
  logic                        deliver;
  logic                        expire;

  // PENABLE from the requesters carries no information we need: the
  // sequencing comes entirely from psel and our own FSM.
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  // Round-robin pick: scan upward from last_grant+1, wrapping at NUM_REQ.
  // One extra bit on cand holds last_grant+k before the wrap subtract.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req_psel_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  // The winner gets the completion only if it is still asking for it.
  assign deliver = !abandon_q && req_psel_i[winner_q];
  assign expire  = !pready_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      winner_q     <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      cnt_q        <= '0;
      abandon_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        last_grant_q <= pick;
        winner_q     <= pick;
        paddr_q      <= req_paddr_i[int'(pick)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        pwdata_q     <= req_pwdata_i[int'(pick)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        pwrite_q     <= req_pwrite_i[pick];
        abandon_q    <= 1'b0;
      end else if (state_q != IDLE && !req_psel_i[winner_q]) begin
        abandon_q <= 1'b1;
      end
      // Counter restarts on the way into ACCESS and counts wait cycles.
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS && !pready_i && !expire) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_o        = 1'b0;
    penable_o     = 1'b0;
    timeout_o     = 1'b0;
    grant_o       = '0;
    req_pready_o  = '0;
    req_pslverr_o = '0;
    req_prdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel_o            = 1'b1;
        grant_o[winner_q] = 1'b1;
        state_d           = ACCESS;
      end
      ACCESS: begin
        psel_o            = 1'b1;
        penable_o         = 1'b1;
        grant_o[winner_q] = 1'b1;
        if (pready_i) begin
          state_d = IDLE;
          if (deliver) begin
            req_pready_o[winner_q]  = 1'b1;
            req_pslverr_o[winner_q] = pslverr_i;
            req_prdata_o[int'(winner_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH] = prdata_i;
          end
        end else if (expire) begin
          // Slave never answered: end the transfer with an error, no data.
          state_d   = IDLE;
          timeout_o = 1'b1;
          if (deliver) begin
            req_pready_o[winner_q]  = 1'b1;
            req_pslverr_o[winner_q] = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign paddr_o  = paddr_q;
  assign pwdata_o = pwdata_q;
  assign pwrite_o = pwrite_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_apb_periph_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_periph_arbiter
//
// Directed scenarios for reset, single read, contention, wait states,
// timeout, reset in ACCESS and winner withdrawal, followed by a randomized
// run against a transaction-level round-robin model. A second instance
// with TIMEOUT_CYCLES=4 shares the inputs and is checked only in the
// timeout scenario.
// ---------------------------------------------------------------------------
module tb_apb_periph_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  // clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]    req_psel, req_penable, req_pwrite;
  logic [N*AW-1:0] req_paddr;
  logic [N*DW-1:0] req_pwdata;
  logic [DW-1:0]   prdata_i;
  logic            pready_i, pslverr_i;

  logic [N*DW-1:0] req_prdata;
  logic [N-1:0]    req_pready, req_pslverr, grant;
  logic            psel, penable, pwrite, timeout;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [1:0]      state;

  logic [N*DW-1:0] t_req_prdata;
  logic [N-1:0]    t_req_pready, t_req_pslverr, t_grant;
  logic            t_psel, t_penable, t_pwrite, t_timeout;
  logic [AW-1:0]   t_paddr;
  logic [DW-1:0]   t_pwdata;
  logic [1:0]      t_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  apb_periph_arbiter #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_psel_i(req_psel), .req_penable_i(req_penable), .req_pwrite_i(req_pwrite),
    .req_paddr_i(req_paddr), .req_pwdata_i(req_pwdata),
    .req_prdata_o(req_prdata), .req_pready_o(req_pready), .req_pslverr_o(req_pslverr),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .grant_o(grant), .timeout_o(timeout), .state_o(state)
  );

  apb_periph_arbiter #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
                       .TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_psel_i(req_psel), .req_penable_i(req_penable), .req_pwrite_i(req_pwrite),
    .req_paddr_i(req_paddr), .req_pwdata_i(req_pwdata),
    .req_prdata_o(t_req_prdata), .req_pready_o(t_req_pready), .req_pslverr_o(t_req_pslverr),
    .psel_o(t_psel), .penable_o(t_penable), .pwrite_o(t_pwrite),
    .paddr_o(t_paddr), .pwdata_o(t_pwdata),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .grant_o(t_grant), .timeout_o(t_timeout), .state_o(t_state)
  );

  // driver tasks
  task automatic clear_inputs();
    req_psel    = '0;
    req_penable = '0;
    req_pwrite  = '0;
    req_paddr   = '0;
    req_pwdata  = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of the first IDLE cycle after release.
  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic wr);
    req_paddr[i*AW +: AW]  = a;
    req_pwdata[i*DW +: DW] = d;
    req_pwrite[i]          = wr;
    req_penable[i]         = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni   = 1'b0;
    clear_inputs();
    req_psel = '1;
    @(posedge clk_i); #1;
    n_cmp++; if (psel !== 1'b0)    begin n_bad++; $display("FAIL reset_psel got %b exp 0", psel); end
    n_cmp++; if (penable !== 1'b0) begin n_bad++; $display("FAIL reset_penable got %b exp 0", penable); end
    n_cmp++; if (grant !== '0)     begin n_bad++; $display("FAIL reset_grant got %b exp 000", grant); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    n_cmp++; if (req_pready !== '0) begin n_bad++; $display("FAIL reset_pready got %b exp 000", req_pready); end
    n_cmp++; if (paddr !== '0)     begin n_bad++; $display("FAIL reset_paddr got %h exp 0", paddr); end
    n_cmp++; if (pwdata !== '0)    begin n_bad++; $display("FAIL reset_pwdata got %h exp 0", pwdata); end
    n_cmp++; if (pwrite !== 1'b0)  begin n_bad++; $display("FAIL reset_pwrite got %b exp 0", pwrite); end
    req_psel = '0;
  endtask

  task automatic test_single_read();
    int psel_cycles;
    psel_cycles = 0;
    do_reset();
    set_req(0, 32'h1A10_4000, 32'h0, 1'b0);
    req_psel[0] = 1'b1;
    pready_i    = 1'b1;
    prdata_i    = 32'hCAFE_F00D;
    // cycle 1: IDLE
    @(negedge clk_i);
    if (psel) psel_cycles++;
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL single_grant_idle got %b exp 000", grant); end
    @(posedge clk_i); #1;
    // cycle 2: SETUP
    @(negedge clk_i);
    if (psel) psel_cycles++;
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL single_grant_setup got %b exp 001", grant); end
    n_cmp++; if (paddr !== 32'h1A10_4000) begin n_bad++; $display("FAIL single_paddr got %h exp 1a104000", paddr); end
    n_cmp++; if (penable !== 1'b0 || req_pready !== 3'b000) begin
      n_bad++; $display("FAIL single_setup got penable=%b pready=%b exp 0/000", penable, req_pready); end
    @(posedge clk_i); #1;
    // cycle 3: ACCESS, slave ready
    @(negedge clk_i);
    if (psel) psel_cycles++;
    n_cmp++; if (req_pready !== 3'b001) begin n_bad++; $display("FAIL single_pready got %b exp 001", req_pready); end
    n_cmp++; if (req_prdata[0 +: DW] !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL single_prdata got %h exp cafef00d", req_prdata[0 +: DW]); end
    n_cmp++; if (req_prdata[DW +: 2*DW] !== '0) begin
      n_bad++; $display("FAIL single_prdata_others got %h exp 0", req_prdata[DW +: 2*DW]); end
    @(posedge clk_i); #1;
    req_psel[0] = 1'b0;
    // cycle 4: back in IDLE
    @(negedge clk_i);
    if (psel) psel_cycles++;
    n_cmp++; if (psel_cycles !== 2) begin n_bad++; $display("FAIL single_psel_cycles got %0d exp 2", psel_cycles); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g, exp_r;
    int t, ph;
    do_reset();
    set_req(0, 32'h0000_0100, 32'h0, 1'b0);
    set_req(1, 32'h0000_0200, 32'h0, 1'b0);
    req_psel = 3'b011;
    pready_i = 1'b1;
    prdata_i = 32'h5555_AAAA;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      t  = (c - 1) / 3;
      ph = (c - 1) % 3;
      exp_g = (ph == 0) ? 3'b000 : (3'b001 << (t % 2));
      exp_r = (ph == 2) ? (3'b001 << (t % 2)) : 3'b000;
      n_cmp++; if (grant !== exp_g) begin n_bad++; $display("FAIL contention_grant c=%0d got %b exp %b", c, grant, exp_g); end
      n_cmp++; if (req_pready !== exp_r) begin n_bad++; $display("FAIL contention_pready c=%0d got %b exp %b", c, req_pready, exp_r); end
      @(posedge clk_i); #1;
    end
    req_psel = '0;
  endtask

  task automatic test_wait_states();
    do_reset();
    set_req(2, 32'h4000_0010, 32'h1234_5678, 1'b1);
    req_psel[2] = 1'b1;
    pready_i    = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL wait_timeout c=%0d got %b exp 0", c, timeout); end
      n_cmp++; if (req_pready !== ((c == 8) ? 3'b100 : 3'b000)) begin
        n_bad++; $display("FAIL wait_pready c=%0d got %b", c, req_pready); end
      if (c == 8) begin
        n_cmp++; if (req_pslverr !== 3'b100) begin n_bad++; $display("FAIL wait_pslverr got %b exp 100", req_pslverr); end
      end
      if (c == 2) begin
        n_cmp++; if (pwdata !== 32'h1234_5678 || pwrite !== 1'b1) begin
          n_bad++; $display("FAIL wait_write_attrs got %h/%b exp 12345678/1", pwdata, pwrite); end
      end
      @(posedge clk_i); #1;
      if (c == 7) begin pready_i = 1'b1; pslverr_i = 1'b1; end
      if (c == 8) begin req_psel = '0; pready_i = 1'b0; pslverr_i = 1'b0; end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(0, 32'h2000_0000, 32'h0, 1'b0);
    req_psel[0] = 1'b1;
    pready_i    = 1'b0;
    prdata_i    = 32'hFFFF_FFFF;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_i);
      n_cmp++; if (t_timeout !== (c == 6)) begin n_bad++; $display("FAIL timeout_pulse c=%0d got %b", c, t_timeout); end
      n_cmp++; if (t_req_pready !== ((c == 6) ? 3'b001 : 3'b000)) begin
        n_bad++; $display("FAIL timeout_pready c=%0d got %b", c, t_req_pready); end
      if (c == 6) begin
        n_cmp++; if (t_req_pslverr !== 3'b001) begin n_bad++; $display("FAIL timeout_pslverr got %b exp 001", t_req_pslverr); end
        n_cmp++; if (t_req_prdata[0 +: DW] !== '0) begin
          n_bad++; $display("FAIL timeout_prdata got %h exp 0", t_req_prdata[0 +: DW]); end
      end
      if (c == 7) begin
        n_cmp++; if (t_psel !== 1'b0) begin n_bad++; $display("FAIL timeout_idle_psel got %b exp 0", t_psel); end
      end
      @(posedge clk_i); #1;
      if (c == 6) req_psel = '0;
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    set_req(1, 32'h3000_0004, 32'hDEAD_BEEF, 1'b1);
    set_req(0, 32'h3000_0008, 32'h0, 1'b0);
    req_psel[1] = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    n_cmp++; if (psel !== 1'b1 || penable !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_access got psel=%b penable=%b exp 1/1", psel, penable); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (psel !== 1'b0 || grant !== '0 || req_pready !== '0) begin
      n_bad++; $display("FAIL rstmid_abort got psel=%b grant=%b pready=%b exp 0/000/000", psel, grant, req_pready); end
    req_psel = 3'b011;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL rstmid_first_grant got %b exp 001", grant); end
    req_psel = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    set_req(1, 32'h5000_0000, 32'h0, 1'b0);
    req_psel[1] = 1'b1;
    pready_i    = 1'b1;
    prdata_i    = $urandom;
    @(posedge clk_i); #1;
    req_psel[1] = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (grant !== 3'b010 || psel !== 1'b1) begin
      n_bad++; $display("FAIL withdraw_setup got grant=%b psel=%b exp 010/1", grant, psel); end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++; if (psel !== 1'b1 || penable !== 1'b1) begin
      n_bad++; $display("FAIL withdraw_access got psel=%b penable=%b exp 1/1", psel, penable); end
    n_cmp++; if (req_pready !== 3'b000) begin n_bad++; $display("FAIL withdraw_pready got %b exp 000", req_pready); end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL withdraw_idle got %b exp 0", psel); end
  endtask

  // Random masters hold psel until served; a random slave inserts 0..3
  // wait states. The model picks winners by round-robin over the requests
  // that were pending in the IDLE cycle and queues the expected owner.
  task automatic test_random();
    int last, w, wait_left, idx;
    logic prev_pen, slave_ready;
    logic [N-1:0] snap_psel, snap_wr, done, exp_r;
    logic [N*AW-1:0] snap_addr;
    logic [N*DW-1:0] snap_wdata;
    do_reset();
    exp_q.delete();
    last = N - 1; wait_left = 0; prev_pen = 1'b0; done = '0;
    snap_psel = req_psel; snap_wr = req_pwrite; snap_addr = req_paddr; snap_wdata = req_pwdata;
    for (int cyc = 0; cyc < 600; cyc++) begin
      // bus observation and reference model
      if (psel && !penable) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (last + k) % N;
          if (w < 0 && snap_psel[idx]) w = idx;
        end
        n_cmp++;
        if (w < 0) begin
          n_bad++; $display("FAIL rand_spurious_setup cyc=%0d grant=%b", cyc, grant);
        end else begin
          if (grant !== (3'b001 << w) || paddr !== snap_addr[w*AW +: AW] || pwrite !== snap_wr[w] ||
              (snap_wr[w] && pwdata !== snap_wdata[w*DW +: DW])) begin
            n_bad++; $display("FAIL rand_grant cyc=%0d got %b/%h exp %b/%h", cyc, grant, paddr,
                              3'b001 << w, snap_addr[w*AW +: AW]);
          end
          exp_q.push_back(3'b001 << w);
          last = w;
        end
      end
      if (psel && penable && !prev_pen) wait_left = $urandom_range(0, 3);
      prev_pen = penable;
      // slave
      if (psel && penable) begin
        pready_i  = (wait_left == 0);
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom_range(0, 1));
        if (wait_left > 0) wait_left--;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'b0;
      end
      // masters
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          done[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
          else req_psel[i] = 1'b0;
        end else if (!req_psel[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
          req_psel[i] = 1'b1;
        end
      end
      snap_psel = req_psel; snap_wr = req_pwrite; snap_addr = req_paddr; snap_wdata = req_pwdata;
      // scoreboard
      @(negedge clk_i);
      slave_ready = psel && penable && pready_i;
      exp_r = '0;
      if (slave_ready) exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (req_pready !== exp_r) begin
        n_bad++; $display("FAIL rand_pready cyc=%0d got %b exp %b", cyc, req_pready, exp_r);
      end else if (exp_r != '0) begin
        for (int i = 0; i < N; i++) begin
          if (exp_r[i]) begin
            n_cmp++;
            if (req_prdata[i*DW +: DW] !== prdata_i || req_pslverr[i] !== pslverr_i) begin
              n_bad++; $display("FAIL rand_resp cyc=%0d got %h/%b exp %h/%b", cyc,
                                req_prdata[i*DW +: DW], req_pslverr[i], prdata_i, pslverr_i);
            end
          end
        end
      end
      done = done | req_pready;
      @(posedge clk_i); #1;
    end
    req_psel = '0;
    pready_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_periph_arbiter.md
APB_PERIPH_ARBITER -- requirements
Module: apb_periph_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 2: number of APB requesters sharing the peripheral bus, range 2..8.
REQ-002 The block SHALL take parameter APB_ADDR_WIDTH, default 32: address width.
REQ-003 The block SHALL take parameter APB_DATA_WIDTH, default 32: data width.
REQ-004 The block SHALL take parameter TIMEOUT_CYCLES, default 255: ACCESS-phase cycles before forced error completion, range 1..65535.
REQ-005 The block SHALL have these ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_psel_i  in  NUM_REQ  per-requester PSEL.
- req_penable_i  in  NUM_REQ  per-requester PENABLE.
- req_pwrite_i  in  NUM_REQ  per-requester PWRITE.
- req_paddr_i  in  NUM_REQ x APB_ADDR_WIDTH  per-requester PADDR.
- req_pwdata_i  in  NUM_REQ x APB_DATA_WIDTH  per-requester PWDATA.
- req_prdata_o  out  NUM_REQ x APB_DATA_WIDTH  per-requester PRDATA.
- req_pready_o  out  NUM_REQ  per-requester PREADY.
- req_pslverr_o  out  NUM_REQ  per-requester PSLVERR.
- psel_o, penable_o, pwrite_o  out  1 each  shared APB master toward the address decoder.
- paddr_o  out  APB_ADDR_WIDTH  shared PADDR.
- pwdata_o  out  APB_DATA_WIDTH  shared PWDATA.
- prdata_i  in  APB_DATA_WIDTH  shared PRDATA.
- pready_i, pslverr_i  in  1 each  shared completion.
- grant_o  out  NUM_REQ  one-hot owner, zero when IDLE.
- timeout_o  out  1  one-cycle pulse on forced completion.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-007 In IDLE, pending = req_psel_i; if pending is non-zero, the block SHALL select a winner round-robin, searching upward from (last_grant+1) mod NUM_REQ, and go to SETUP on the next edge.
REQ-008 On selection, the block SHALL register the winner index into last_grant and register its paddr, pwrite and pwdata; shared outputs SHALL drive only these registered values.
REQ-009 In SETUP, the block SHALL drive psel_o=1 and penable_o=0, then go to ACCESS unconditionally.
REQ-010 In ACCESS, the block SHALL drive psel_o=1 and penable_o=1; a 16-bit timeout counter starts at 0 on entry and increments each ACCESS cycle with pready_i=0.
REQ-011 In ACCESS with pready_i=1, in the same cycle the winner SHALL get req_pready_o=1, req_prdata_o=prdata_i and req_pslverr_o=pslverr_i; the FSM then goes to IDLE.
REQ-012 In ACCESS with pready_i=0 and counter==TIMEOUT_CYCLES-1, the winner SHALL get req_pready_o=1, req_pslverr_o=1 and req_prdata_o=0; timeout_o=1 that cycle and the FSM goes to IDLE.
REQ-013 Non-winners SHALL see req_pready_o=0, req_pslverr_o=0 and req_prdata_o=0 at all times.
REQ-014 Minimum latency SHALL be 3 cycles from a request sampled in IDLE to its req_pready_o (IDLE, SETUP, ACCESS with pready_i=1); sustained throughput SHALL be one transfer per 3 cycles.
REQ-015 A requester that keeps psel high after completion SHALL be treated as a new request in the following IDLE cycle, subject to round-robin.
REQ-016 If the winner deasserts psel during SETUP or ACCESS, the transfer SHALL still complete on the shared bus and its response SHALL be discarded (req_pready_o=0).
REQ-017 Requester psel changes outside IDLE SHALL NOT affect arbitration; req_penable_i SHALL be ignored for sequencing.
REQ-018 grant_o SHALL be one-hot of the winner in SETUP and ACCESS, and all-zero in IDLE.
REQ-019 In IDLE the block SHALL drive psel_o=0 and penable_o=0; paddr_o, pwdata_o and pwrite_o SHALL hold their last registered values.

Reset
REQ-020 Asserting rst_ni low SHALL immediately force IDLE, psel_o=0, penable_o=0, grant_o=0, timeout_o=0, all req_pready_o=0, counter=0, last_grant=NUM_REQ-1 (requester 0 wins first), and registered paddr, pwdata and pwrite=0.
REQ-021 Reset during SETUP or ACCESS SHALL abort the transfer with no requester completion; after release the FSM SHALL re-arbitrate from IDLE.

Verification
REQ-022 Single read: req0 psel=1, paddr=0x1A10_4000; slave pready=1, prdata=0xCAFE_F00D on the first ACCESS cycle -> req_pready_o[0]=1 on cycle 3 with data 0xCAFE_F00D; psel_o high 2 cycles.
REQ-023 Contention: req0 and req1 both held high after reset -> grants alternate 0,1,0,1 over 4 transfers, each 3 cycles, with no idle gaps beyond IDLE.
REQ-024 Wait states: pready_i low for 5 ACCESS cycles, then high with pslverr_i=1 -> winner sees pready=1, pslverr=1 on cycle 8; timeout_o stays 0.
REQ-025 Timeout: TIMEOUT_CYCLES=4 and pready_i stuck low -> after 4 ACCESS cycles winner sees pready=1, pslverr=1, prdata=0; timeout_o pulses for 1 cycle; FSM returns to IDLE.
REQ-026 Reset mid-ACCESS: rst_ni low during a req1 write -> psel_o=0 immediately; after release, req0 and req1 pending -> req0 granted first.
REQ-027 Winner withdraws: req1 drops psel in SETUP -> shared ACCESS still occurs and req_pready_o[1] stays 0.
